// File: rtl/pipe_wall_skid_if.sv
// Handshake bundle for the two-wall skid stage. The master side is upstream/downstream
// traffic plus flush; the slave side is the stage controller itself.
interface pipe_wall_skid_if #(
    parameter int LENGTH = 74
);
    // Valid/ready rule on both sides: a transfer happens on a rising clk edge exactly when
    // valid and ready are both 1; a valid entry and its data stay put until transferred.
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [LENGTH-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [LENGTH-1:0] out_data;
    logic [1:0]        occupancy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_wall_skid_ctrl.sv
// Two-entry skid stage (main wall + skid wall) with registered in_ready and single-cycle flush.
// Optional stall counter output enabled by defining PIPE_WALL_STALL_CNT_EN.
module pipe_wall_skid_ctrl #(
    parameter int LENGTH = 74
) (
    input  logic                clk,
    input  logic                reset,
    pipe_wall_skid_if.slave     bus
`ifdef PIPE_WALL_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    // Encoding equals the entry count, so occupancy doubles as the visible FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              out_valid_q;
    logic              not_full_q;
    logic [LENGTH-1:0] main_q;
    logic [LENGTH-1:0] skid_q;
    logic [LENGTH-1:0] main_d;

    logic acc;
    logic deq;
    logic main_en;
    logic skid_en;
    logic main_sel_skid;
    logic in_ready_w;

    assign in_ready_w    = reset & not_full_q;
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.occupancy = state_q;

    assign acc = bus.in_valid & in_ready_w;
    assign deq = out_valid_q & bus.out_ready;

    always_comb begin
        state_d       = state_q;
        main_en       = 1'b0;
        skid_en       = 1'b0;
        main_sel_skid = 1'b0;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_en = 1'b1;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (acc && deq) begin
                        main_en = 1'b1;
                    end else if (acc) begin
                        skid_en = 1'b1;
                        state_d = TWO;
                    end else if (deq) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // Upstream is blocked here, so the only move is skid -> main.
                    if (deq) begin
                        main_en       = 1'b1;
                        main_sel_skid = 1'b1;
                        state_d       = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign main_d = main_sel_skid ? skid_q : bus.in_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            not_full_q  <= 1'b1;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != EMPTY);
            not_full_q  <= (state_d != TWO);
            if (main_en) main_q <= main_d;
            if (skid_en) skid_q <= bus.in_data;
        end
    end

`ifdef PIPE_WALL_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid_q && !bus.out_ready && !bus.flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_wall_skid_ctrl.md
Name: pipe_wall_skid_ctrl

Overview:
- Valid/ready pipeline-stage controller that sequences two LENGTH-wide enable-DFF register walls: a main wall and a skid wall.
- Used between out-of-order pipeline stages, e.g. decode->rename or rename->issue, to break the combinational ready path.
- Sustains full throughput with registered in_ready, and supports a single-cycle flush for mispredict recovery.

Parameters:
LENGTH, 74, payload width in bits (the micro-op bundle width)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
flush  input  1  synchronous discard of all held entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept; depends only on registered state and reset
in_data  input  LENGTH  upstream payload
out_valid  output  1  main wall holds a valid entry
out_ready  input  1  downstream accepts
out_data  output  LENGTH  main wall contents
occupancy  output  2  entries held (0, 1 or 2)

Behaviour:
- Datapath:
  - main_q and skid_q are enable-DFF walls.
  - main_d mux selects in_data or skid_q; skid_d = in_data.
  - The block produces main_en, skid_en and the main mux select.
- Handshake events:
  - acc = in_valid & in_ready.
  - deq = out_valid & out_ready.
- Reset (reset==0 at a clk edge):
  - state=EMPTY; main_q=0; skid_q=0; out_valid=0; occupancy=0.
  - While reset is held low, in_ready=0 (combinationally gated).
- States: EMPTY (occ 0), ONE (occ 1), TWO (occ 2).
  - out_valid = (state != EMPTY).
  - in_ready = reset & (state != TWO).
- EMPTY:
  - acc -> main<=in_data, go to ONE.
  - Otherwise stay.
- ONE:
  - acc&deq -> main<=in_data, stay in ONE.
  - acc&!deq -> skid<=in_data, go to TWO.
  - !acc&deq -> go to EMPTY.
  - Neither -> stay; main holds.
- TWO:
  - deq -> main<=skid_q, go to ONE. in_valid is ignored because in_ready=0.
  - !deq -> hold both walls.
- Latency and ordering:
  - Latency in_data -> out_data is 1 cycle from EMPTY.
  - Throughput is 1 entry/cycle when out_ready is held high.
  - Strict FIFO order.
- Enables:
  - A wall's enable is high only on the load cases above.
  - Data holds when its enable is low, including across idle cycles.
- out_data stability: stable whenever out_valid=1 and out_ready=0; must not change until deq.
- flush=1 at a clk edge (priority below reset, above all else):
  - state -> EMPTY; any acc or deq in that cycle has no effect on state.
  - Wall data is not cleared; enables are low.
  - in_ready remains 1 during the flush cycle, but an accepted entry is discarded.
  - After flush, out_valid=0 on the next cycle.
- Simultaneous flush and reset low: reset wins, and the walls clear to 0.
- Reset mid-operation: held entries are lost and the state returns to EMPTY at that edge.

Optional Feature:
- Macro: PIPE_WALL_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0].
  - Increments each cycle with out_valid & !out_ready & !flush.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by reset; unaffected by flush.
- Undefined: no port, no counter logic. Core behaviour is identical in both builds.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, occupancy=0, out_data=0. After release: in_ready=1.
- Streaming: out_ready=1; in_data = 74'h1, 74'h2, 74'h3 on consecutive cycles -> out_data shows 1, 2, 3 one cycle later each; occupancy stays 1; no bubbles.
- Backpressure/skid:
  - Load 74'hA, then with out_ready=0 load 74'hB -> occupancy=2, in_ready=0, out_data=A held.
  - Raise out_ready -> A, then B dequeued in order; in_ready returns to 1 one cycle after the first deq.
- Flush: with occupancy=2, assert flush together with in_valid=1 (74'hC) -> next cycle out_valid=0, occupancy=0; C is never output.
- Reset mid-stream: with occupancy=2, drive reset=0 for one edge -> state EMPTY, out_data=0; subsequent input 74'h5 emerges 1 cycle after acceptance.
- PIPE_WALL_STALL_CNT_EN: hold out_valid=1 with out_ready=0 for 10 cycles -> stall_cnt=10. Force 70000 stall cycles -> stall_cnt=16'hFFFF.
